// File: rtl/bus_dma_master.sv
`default_nettype none
// ============================================================================
// Module  : bus_dma_master
// Brief   : Word-copy DMA initiator sharing the CPU data bus under arbiter grant.
// Revision: 1.0
// ============================================================================
module bus_dma_master #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             bus_grant,
    input  logic [31:0]      Read_data,
    output logic [31:0]      Address,
    output logic [31:0]      Write_data,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [LEN_W-1:0] xfer_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_WRITE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_src_ptr;
    logic [31:0]      r_dst_ptr;
    logic [31:0]      r_data;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] r_xfer_count;
    logic             r_aborted;
    logic             w_rd_go;
    logic             w_wr_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Bus outputs stay at zero unless a granted, non-aborted transfer cycle.
    always_comb begin
        w_next     = r_state;
        Address    = '0;
        Write_data = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        w_rd_go    = 1'b0;
        w_wr_go    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (len != '0) ? S_READ : S_FINISH;
                end
            end
            S_READ: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (bus_grant) begin
                    Address = r_src_ptr;
                    MemRead = 1'b1;
                    w_rd_go = 1'b1;
                    w_next  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (bus_grant) begin
                    Address    = r_dst_ptr;
                    Write_data = r_data;
                    MemWrite   = 1'b1;
                    w_wr_go    = 1'b1;
                    w_next     = (r_remaining > LEN_W'(1)) ? S_READ : S_FINISH;
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_ptr    <= '0;
            r_dst_ptr    <= '0;
            r_data       <= '0;
            r_remaining  <= '0;
            r_xfer_count <= '0;
            r_aborted    <= 1'b0;
        end else begin
            r_aborted <= abort && ((r_state == S_READ) || (r_state == S_WRITE));
            if ((r_state == S_IDLE) && start) begin
                r_xfer_count <= '0;
                if (len != '0) begin
                    r_src_ptr   <= src_addr & 32'hFFFF_FFFC;
                    r_dst_ptr   <= dst_addr & 32'hFFFF_FFFC;
                    r_remaining <= len;
                end
            end
            if (w_rd_go) begin
                r_data    <= Read_data;
                r_src_ptr <= r_src_ptr + 32'd4;
            end
            if (w_wr_go) begin
                r_dst_ptr    <= r_dst_ptr + 32'd4;
                r_remaining  <= r_remaining - LEN_W'(1);
                r_xfer_count <= r_xfer_count + LEN_W'(1);
            end
        end
    end

    assign busy       = (r_state == S_READ) || (r_state == S_WRITE);
    assign done       = (r_state == S_FINISH);
    assign aborted    = r_aborted;
    assign xfer_count = r_xfer_count;

endmodule
`default_nettype wire

// File: tb/tb_bus_dma_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_dma_master
// Brief   : Randomized self-checking bench with a word-copy memory model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_bus_dma_master;

    localparam int          LEN_W = 16;
    localparam logic [31:0] LED_A = 32'h4000_000C;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             bus_grant;
    logic [31:0]      Read_data;
    logic [31:0]      Address;
    logic [31:0]      Write_data;
    logic             MemRead;
    logic             MemWrite;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [LEN_W-1:0] xfer_count;

    logic [31:0] mem     [1024];
    logic [31:0] exp_mem [1024];
    logic [31:0] leds;
    logic [31:0] exp_leds;
    logic [31:0] rd_q [$];
    logic [31:0] wr_q [$];
    bit          op_q [$];
    logic        mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bus_dma_master #(.LEN_W(LEN_W)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .abort      (abort),
        .bus_grant  (bus_grant),
        .Read_data  (Read_data),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .xfer_count (xfer_count)
    );

    // Bus slave: word RAM aliased over the low 4 KB, plus an LED register.
    always_comb Read_data = (Address == LED_A) ? leds : mem[Address[11:2]];

    always @(posedge clk) begin
        if (MemWrite) begin
            if (Address == LED_A) leds <= Write_data;
            else                  mem[Address[11:2]] <= Write_data;
            wr_q.push_back(Address);
            op_q.push_back(1'b1);
        end
        if (MemRead) begin
            rd_q.push_back(Address);
            op_q.push_back(1'b0);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("strobe_without_grant", 64'((MemRead | MemWrite) & ~bus_grant), 64'd0);
            check("strobe_without_busy",  64'((MemRead | MemWrite) & ~busy), 64'd0);
            check("read_and_write",       64'(MemRead & MemWrite), 64'd0);
            check("done_with_aborted",    64'(done & aborted), 64'd0);
            if (!(MemRead || MemWrite))
                check("idle_bus_nonzero", {Address, Write_data}, 64'd0);
        end
    end

    // Reference: sequential word copy, each word read then written.
    task automatic model_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
        logic [31:0] a, b, v;
        exp_mem  = mem;
        exp_leds = leds;
        for (int k = 0; k < n; k++) begin
            a = (src & 32'hFFFF_FFFC) + 32'(4 * k);
            b = (dst & 32'hFFFF_FFFC) + 32'(4 * k);
            v = (a == LED_A) ? exp_leds : exp_mem[a[11:2]];
            if (b == LED_A) exp_leds = v;
            else            exp_mem[b[11:2]] = v;
        end
    endtask

    task automatic cmp_mem(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== exp_mem[i]) bad++;
        check(tag, 64'(bad), 64'd0);
        check({tag, "_leds"}, leds, exp_leds);
    endtask

    task automatic do_copy(input logic [31:0] src, input logic [31:0] dst, input int n,
                           input logic [63:0] lowmask, input int stall_pct, input bit noise,
                           output int done_cyc);
        logic [31:0] s, d;
        int cyc, g, st, bad;
        bit seen;
        s = src & 32'hFFFF_FFFC;
        d = dst & 32'hFFFF_FFFC;
        model_copy(src, dst, n);
        rd_q.delete();
        wr_q.delete();
        op_q.delete();
        @(negedge clk);
        src_addr = src;
        dst_addr = dst;
        len      = LEN_W'(n);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc  = 1;
        g    = 0;
        st   = 0;
        seen = 0;
        while (cyc < 4 * n + 200) begin
            bus_grant = !((cyc < 64) && lowmask[cyc]) && ($urandom_range(99) >= stall_pct);
            if (noise) begin
                start    = ($urandom_range(7) == 0);
                src_addr = $urandom;
                dst_addr = $urandom;
                len      = LEN_W'($urandom);
            end
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) begin
                if (bus_grant) g++;
                else           st++;
            end
            @(posedge clk);
            #1 cyc++;
        end
        start    = 1'b0;
        done_cyc = cyc;
        check("done_seen", 64'(seen), 64'd1);
        check("granted_cycles", 64'(g), 64'(2 * n));
        check("done_cycle", 64'(cyc), 64'(2 * n + 1 + st));
        check("xfer_count", 64'(xfer_count), 64'(n));
        check("busy_in_finish", 64'(busy), 64'd0);
        check("num_reads", 64'(rd_q.size()), 64'(n));
        check("num_writes", 64'(wr_q.size()), 64'(n));
        bad = 0;
        for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] !== s + 32'(4 * i)) bad++;
        for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== d + 32'(4 * i)) bad++;
        for (int i = 0; i < op_q.size(); i++) if (op_q[i] !== i[0]) bad++;
        check("addr_sequence", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        cmp_mem("copy_mem");
    endtask

    initial begin
        int dc;
        int hits;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        bus_grant = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        len       = '0;
        leds      = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_outputs", {Address, Write_data, MemRead, MemWrite, busy, done, aborted},
              64'd0);
        check("reset_xfer_count", 64'(xfer_count), 64'd0);

        // Basic copy of four words with grant held high.
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        do_copy(32'h0, 32'h100, 4, 64'd0, 0, 0, dc);
        check("basic_done_cycle", 64'(dc), 64'd9);
        check("basic_dst_word3", mem[67], 32'h44);

        // Zero length completes immediately with no bus activity.
        do_copy(32'h40, 32'h140, 0, 64'd0, 0, 0, dc);
        check("zero_done_cycle", 64'(dc), 64'd1);

        // Three ungranted cycles during the first write.
        do_copy(32'h20, 32'h180, 2, 64'b11100, 0, 0, dc);
        check("stall_done_cycle", 64'(dc), 64'd8);

        // Peripheral destination.
        mem[0] = 32'h0000_00A5;
        do_copy(32'h0, LED_A, 1, 64'd0, 0, 0, dc);
        check("leds_value", leds, 32'h0000_00A5);

        // Abort during the third read.
        model_copy(32'h40, 32'h300, 2);
        @(negedge clk);
        src_addr = 32'h40; dst_addr = 32'h300; len = LEN_W'(8); start = 1'b1; bus_grant = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(negedge clk);
        check("abort_no_read", {31'd0, MemRead, Address}, 64'd0);
        check("abort_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("aborted_pulse", {aborted, busy, done}, 64'b100);
        check("abort_xfer_count", 64'(xfer_count), 64'd2);
        hits = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || aborted || busy) hits++;
        end
        check("after_abort_quiet", 64'(hits), 64'd0);
        cmp_mem("abort_mem");

        // Reset during a write.
        @(negedge clk);
        src_addr = 32'h0; dst_addr = 32'h1C0; len = LEN_W'(4); start = 1'b1; bus_grant = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("write_before_reset", 64'(MemWrite), 64'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_mid_outputs", {Address, Write_data, MemRead, MemWrite, busy, done, aborted},
              64'd0);
        check("reset_mid_xfer", 64'(xfer_count), 64'd0);

        // Unaligned source that wraps through the top of the address space.
        do_copy(32'hFFFF_FFFD, 32'h200, 2, 64'd0, 0, 0, dc);
        if (rd_q.size() == 2) begin
            check("wrap_read0", rd_q[0], 32'hFFFF_FFFC);
            check("wrap_read1", rd_q[1], 32'h0000_0000);
        end else begin
            check("wrap_read_count", 64'(rd_q.size()), 64'd2);
        end

        // Randomized copies with random grant stalls and ignored start pulses.
        for (int t = 0; t < 20; t++) begin
            do_copy($urandom & 32'h0000_0FFF, $urandom & 32'h0000_0FFF,
                    int'($urandom_range(0, 12)), 64'd0, int'($urandom_range(0, 40)), 1'b1, dc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
